max_score_collect: RTL and testbench
====================================

# max_score_collect

Downstream stage of the interleaved running-max comparator. It takes that stage's per-cycle `max`/`location_out` stream, which carries LANES time-interleaved alignment lanes. On each lane's final sample it captures the lane's best score and location into a small FIFO. The FIFO is drained toward the traceback/CIGAR controller through a valid/ready handshake.

## Interface
- `CMP_WIDTH`, 16: signed score width.
- `LOCATION_WIDTH`, 32: location width.
- `LANES`, 6: interleave factor; must equal the comparator pipeline depth.
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `clk`  in  1  single clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_en`  in  1  comparator enable, aligned with `max_in`.
- `in_last`  in  1  current sample is the final one for the lane in the current slot.
- `max_in`  in  CMP_WIDTH  signed running max.
- `loc_in`  in  LOCATION_WIDTH  location of `max_in`.
- `score_thresh`  in  CMP_WIDTH  signed minimum score. Used only when the threshold feature is compiled in.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  consumer accepts head.
- `out_lane`  out  $clog2(LANES)  slot index of captured lane.
- `out_max`  out  CMP_WIDTH  captured score.
- `out_loc`  out  LOCATION_WIDTH  captured location.
- `fifo_cnt`  out  $clog2(DEPTH)+1  occupancy.
- `overflow`  out  1  sticky: a capture was lost because the FIFO was full.

## Operation
- Slot counter `slot`:
  - Zeroed when `in_en`=0.
  - With `in_en`=1, advances 0→1→…→LANES-1→0 once per cycle.
  - The sample on a given cycle belongs to the current `slot` value.
- Capture condition: `in_en && in_last` on a rising edge. The entry written is {`slot`, `max_in`, `loc_in`}.
- `in_last` with `in_en`=0 is ignored. `max_in` is then the comparator's idle sentinel and must never be stored.
- Pop: `out_valid && out_ready` on an edge removes the head.
- FIFO is full when `fifo_cnt`==DEPTH and empty when it is 0. Read and write pointers wrap modulo DEPTH.
- Push on a full FIFO without a simultaneous pop:
  - the entry is dropped;
  - `overflow` sets and stays 1 until `rst`;
  - pointers and count are unchanged.
- Push and pop on the same edge:
  - when full: both occur and the count stays DEPTH; no overflow;
  - when empty: the push is accepted; there is no pop, because `out_valid` was 0.
- `fifo_cnt` changes by +1 (push only), −1 (pop only), or 0 (both or neither).
- Head fields are driven from the registered FIFO storage at the read pointer. They are stable while `out_valid && !out_ready`.
- When empty, `out_lane`/`out_max`/`out_loc` read as 0.
- Scores are compared signed and stored unmodified, with no width change.

## Timing
- Reset values: `out_valid`=0, `out_lane`=0, `out_max`=0, `out_loc`=0, `fifo_cnt`=0, `overflow`=0. Slot counter, pointers and count are also 0.
- `rst` mid-operation empties the FIFO on that edge and discards all queued entries. A capture or pop on the same edge is ignored.
- Latency: a capture on edge k gives `out_valid`=1 in cycle k+1 if the FIFO was empty.
- Throughput: one capture per cycle sustained and one pop per cycle. With both active the occupancy is stable.
- No combinational path from `out_ready` to `out_valid` or to the head fields.

## Configuration
- `MAX_COLLECT_THRESH_EN` defined:
  - a capture is pushed only if `max_in >= score_thresh` (signed);
  - below-threshold captures neither occupy the FIFO nor set `overflow`.
- Not defined: `score_thresh` is unused and every capture is pushed.

## Test plan
- Single capture: reset, `in_en`=1 for 3 cycles, `in_last`=1 on the 3rd with `max_in`=25, `loc_in`=0x100 → cycle after: `out_valid`=1, `out_lane`=2, `out_max`=25, `out_loc`=0x100, `fifo_cnt`=1. Pulse `out_ready` → `out_valid`=0, `fifo_cnt`=0.
- Slot wrap: `in_en`=1 for 8 cycles, `in_last` on cycles 1 and 8 → lanes 0 then 1, popped in that order.
- Full and overflow (DEPTH=8, `out_ready`=0): 9 captures with `max_in`=1..9 → `fifo_cnt`=8, `overflow`=1. Drain yields 1..8 and value 9 is absent.
- Full plus simultaneous pop: FIFO full, one edge with capture (`max_in`=-3) and `out_ready`=1 → `fifo_cnt`=8, `overflow`=0, last entry popped is -3.
- Idle and reset: `in_last`=1 while `in_en`=0 → no push. `rst` with 4 entries queued and `out_ready`=1 → next cycle `fifo_cnt`=0, `out_valid`=0.
- Threshold (macro on, `score_thresh`=10): captures of 9, 10, -20, 11 → FIFO holds 10, 11.

Source files
------------

// File: rtl/max_score_collect_if.sv
// max_score_collect_if
// Bundles the comparator-side capture inputs and the consumer-side FIFO
// handshake of max_score_collect.
//   slave  : the collector (consumes in_*, drives out_*, fifo_cnt, overflow)
//   master : the environment (drives in_*, score_thresh, out_ready)
// Handshake: an entry transfers on a rising clk edge where out_valid and
// out_ready are both 1. out_valid never depends on out_ready, and the head
// fields hold steady while out_valid && !out_ready.
interface max_score_collect_if #(
  parameter int CMP_WIDTH      = 16,
  parameter int LOCATION_WIDTH = 32,
  parameter int LANES          = 6,
  parameter int DEPTH          = 8
);
  localparam int LANE_W = $clog2(LANES);
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic                      in_en;
  logic                      in_last;
  logic [CMP_WIDTH-1:0]      max_in;
  logic [LOCATION_WIDTH-1:0] loc_in;
  logic [CMP_WIDTH-1:0]      score_thresh;
  logic                      out_valid;
  logic                      out_ready;
  logic [LANE_W-1:0]         out_lane;
  logic [CMP_WIDTH-1:0]      out_max;
  logic [LOCATION_WIDTH-1:0] out_loc;
  logic [CNT_W-1:0]          fifo_cnt;
  logic                      overflow;

  modport slave (
    input  in_en, in_last, max_in, loc_in, score_thresh, out_ready,
    output out_valid, out_lane, out_max, out_loc, fifo_cnt, overflow
  );

  modport master (
    output in_en, in_last, max_in, loc_in, score_thresh, out_ready,
    input  out_valid, out_lane, out_max, out_loc, fifo_cnt, overflow
  );
endinterface

// File: rtl/max_score_collect.sv
// max_score_collect
// Follows the running-max comparator stream of LANES time-interleaved
// lanes. On a lane's final sample (in_en && in_last) the {slot, max, loc}
// triple is pushed into a DEPTH-entry FIFO that drains with a valid/ready
// handshake toward the traceback controller.
// Ports:
//   clk, rst : single clock, synchronous active-high reset
//   bus      : max_score_collect_if.slave (capture inputs, FIFO head,
//              out_ready, fifo_cnt, sticky overflow)
// Optional feature: define MAX_COLLECT_THRESH_EN to push only captures with
// max_in >= score_thresh (signed); rejected captures never count as overflow.
module max_score_collect #(
  parameter int CMP_WIDTH      = 16,
  parameter int LOCATION_WIDTH = 32,
  parameter int LANES          = 6,
  parameter int DEPTH          = 8
) (
  input logic               clk,
  input logic               rst,
  max_score_collect_if.slave bus
);
  localparam int LANE_W  = $clog2(LANES);
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = LANE_W + CMP_WIDTH + LOCATION_WIDTH;

  logic [LANE_W-1:0]  slot_q, slot_d;
  logic [PTR_W-1:0]   wptr_q, wptr_d;
  logic [PTR_W-1:0]   rptr_q, rptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [ENTRY_W-1:0] mem_q [DEPTH];

  logic capture, push_req, push_ok, pop, full, empty;
  logic [ENTRY_W-1:0] head;

  assign capture = bus.in_en && bus.in_last;

`ifdef MAX_COLLECT_THRESH_EN
  assign push_req = capture && ($signed(bus.max_in) >= $signed(bus.score_thresh));
`else
  logic unused_thresh;
  assign unused_thresh = ^bus.score_thresh;
  assign push_req = capture;
`endif

  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign empty = (cnt_q == '0);
  assign pop   = !empty && bus.out_ready;
  // A full FIFO still takes a push when the head leaves on the same edge.
  assign push_ok = push_req && (!full || pop);

  always_comb begin
    slot_d = slot_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;

    // Slot tracks which interleaved lane owns the current sample.
    if (!bus.in_en)                         slot_d = '0;
    else if (slot_q == LANE_W'(LANES - 1))  slot_d = '0;
    else                                    slot_d = slot_q + 1'b1;

    if (push_ok) wptr_d = wptr_q + 1'b1;
    if (pop)     rptr_d = rptr_q + 1'b1;

    case ({push_ok, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    if (push_req && !push_ok) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      slot_q <= slot_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

  // Storage needs no reset: it is only visible through the valid-gated head.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem_q[wptr_q] <= {slot_q, bus.max_in, bus.loc_in};
  end

  assign head = empty ? '0 : mem_q[rptr_q];

  assign bus.out_valid = !empty;
  assign bus.out_lane  = head[ENTRY_W-1 -: LANE_W];
  assign bus.out_max   = head[LOCATION_WIDTH +: CMP_WIDTH];
  assign bus.out_loc   = head[LOCATION_WIDTH-1:0];
  assign bus.fifo_cnt  = cnt_q;
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_max_score_collect.sv
// tb_max_score_collect
// Directed-vector bench for max_score_collect (CMP_WIDTH=16,
// LOCATION_WIDTH=32, LANES=6, DEPTH=8). Inputs change 1 time unit after
// each rising edge; outputs are checked at that same point.
module tb_max_score_collect;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  max_score_collect_if #(.CMP_WIDTH(16), .LOCATION_WIDTH(32), .LANES(6), .DEPTH(8)) bus ();

  max_score_collect #(.CMP_WIDTH(16), .LOCATION_WIDTH(32), .LANES(6), .DEPTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock with the given inputs applied, returning 1 unit after the edge.
  task automatic cyc(input logic en, input logic last, input logic [15:0] mx,
                     input logic [31:0] loc, input logic rdy);
    bus.in_en     = en;
    bus.in_last   = last;
    bus.max_in    = mx;
    bus.loc_in    = loc;
    bus.out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  // Check the head against expectations, then pop it.
  task automatic pop_exp(input string tag, input logic [2:0] lane,
                         input logic [15:0] mx, input logic [31:0] loc);
    check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    check({tag, "_lane"},  64'(bus.out_lane),  64'(lane));
    check({tag, "_max"},   64'(bus.out_max),   64'(mx));
    check({tag, "_loc"},   64'(bus.out_loc),   64'(loc));
    cyc(1'b0, 1'b0, 16'h0, 32'h0, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1'b0, 1'b0, 16'h0, 32'h0, 1'b0);
    cyc(1'b0, 1'b0, 16'h0, 32'h0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    bus.score_thresh = 16'sd10;
    do_reset();

    // reset state
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_lane",  64'(bus.out_lane),  64'd0);
    check("rst_max",   64'(bus.out_max),   64'd0);
    check("rst_loc",   64'(bus.out_loc),   64'd0);
    check("rst_cnt",   64'(bus.fifo_cnt),  64'd0);
    check("rst_ovf",   64'(bus.overflow),  64'd0);

    // single capture on the third enabled cycle -> lane 2
    cyc(1'b1, 1'b0, 16'd3,  32'h0,   1'b0);
    cyc(1'b1, 1'b0, 16'd4,  32'h0,   1'b0);
    cyc(1'b1, 1'b1, 16'd25, 32'h100, 1'b0);
    check("single_valid", 64'(bus.out_valid), 64'd1);
    check("single_lane",  64'(bus.out_lane),  64'd2);
    check("single_max",   64'(bus.out_max),   64'd25);
    check("single_loc",   64'(bus.out_loc),   64'h100);
    check("single_cnt",   64'(bus.fifo_cnt),  64'd1);
    cyc(1'b0, 1'b0, 16'h0, 32'h0, 1'b1);
    check("single_pop_valid", 64'(bus.out_valid), 64'd0);
    check("single_pop_cnt",   64'(bus.fifo_cnt),  64'd0);
    check("empty_max",        64'(bus.out_max),   64'd0);

    // slot wrap: last on enabled cycles 1 and 8 -> lanes 0 and 1
    for (int i = 1; i <= 8; i++)
      cyc(1'b1, (i == 1 || i == 8), 16'(i * 5), 32'(32'h200 + i), 1'b0);
    cyc(1'b0, 1'b0, 16'h0, 32'h0, 1'b0);
    check("wrap_cnt", 64'(bus.fifo_cnt), 64'd2);
    pop_exp("wrap0", 3'd0, 16'd5,  32'h201);
    pop_exp("wrap1", 3'd1, 16'd40, 32'h208);
    check("wrap_empty", 64'(bus.fifo_cnt), 64'd0);

    // full and overflow: nine captures into eight entries
    for (int i = 1; i <= 9; i++)
      cyc(1'b1, 1'b1, 16'(i), 32'(32'h300 + i), 1'b0);
    cyc(1'b0, 1'b0, 16'h0, 32'h0, 1'b0);
    check("full_cnt", 64'(bus.fifo_cnt), 64'd8);
    check("full_ovf", 64'(bus.overflow), 64'd1);
    // head must hold while not ready
    cyc(1'b0, 1'b0, 16'h0, 32'h0, 1'b0);
    check("hold_max", 64'(bus.out_max), 64'd1);
    for (int i = 1; i <= 8; i++)
      pop_exp($sformatf("drain%0d", i), 3'((i - 1) % 6), 16'(i), 32'(32'h300 + i));
    check("drain_cnt",   64'(bus.fifo_cnt),  64'd0);
    check("drain_valid", 64'(bus.out_valid), 64'd0);
    check("ovf_sticky",  64'(bus.overflow),  64'd1);

    do_reset();
    check("ovf_cleared", 64'(bus.overflow), 64'd0);

    // full plus simultaneous pop: accepted, no overflow
    for (int i = 1; i <= 8; i++)
      cyc(1'b1, 1'b1, 16'(i), 32'(32'h400 + i), 1'b0);
    check("fp_full", 64'(bus.fifo_cnt), 64'd8);
    cyc(1'b1, 1'b1, 16'hFFFD, 32'h4FF, 1'b1);  // slot 8 mod 6 = 2
    bus.in_en = 1'b0;
    check("fp_cnt", 64'(bus.fifo_cnt), 64'd8);
    check("fp_ovf", 64'(bus.overflow), 64'd0);
    for (int i = 2; i <= 8; i++)
      pop_exp($sformatf("fp%0d", i), 3'((i - 1) % 6), 16'(i), 32'(32'h400 + i));
    pop_exp("fp_last", 3'd2, 16'hFFFD, 32'h4FF);
    check("fp_empty", 64'(bus.fifo_cnt), 64'd0);

    // push and ready on an empty FIFO: push taken, nothing popped
    cyc(1'b1, 1'b1, 16'd7, 32'h500, 1'b1);
    check("ep_cnt", 64'(bus.fifo_cnt), 64'd1);
    pop_exp("ep", 3'd0, 16'd7, 32'h500);

    // idle in_last with sentinel must never be stored
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 1'b1, 16'h8000, 32'hDEAD, 1'b0);
    check("idle_cnt",   64'(bus.fifo_cnt),  64'd0);
    check("idle_valid", 64'(bus.out_valid), 64'd0);

    // reset mid-operation with captures and ready on the same edge
    for (int i = 1; i <= 4; i++)
      cyc(1'b1, 1'b1, 16'(i), 32'h600, 1'b0);
    check("pre_rst_cnt", 64'(bus.fifo_cnt), 64'd4);
    rst = 1'b1;
    cyc(1'b1, 1'b1, 16'd99, 32'h601, 1'b1);
    rst = 1'b0;
    check("mid_rst_cnt",   64'(bus.fifo_cnt),  64'd0);
    check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    cyc(1'b0, 1'b0, 16'h0, 32'h0, 1'b0);
    check("post_rst_cnt",  64'(bus.fifo_cnt),  64'd0);

    // threshold 10 with captures 9, 10, -20, 11
    cyc(1'b1, 1'b1, 16'd9,    32'h700, 1'b0);
    cyc(1'b1, 1'b1, 16'd10,   32'h701, 1'b0);
    cyc(1'b1, 1'b1, 16'hFFEC, 32'h702, 1'b0);
    cyc(1'b1, 1'b1, 16'd11,   32'h703, 1'b0);
    bus.in_en = 1'b0;
`ifdef MAX_COLLECT_THRESH_EN
    check("thr_cnt", 64'(bus.fifo_cnt), 64'd2);
    pop_exp("thr10", 3'd1, 16'd10, 32'h701);
    pop_exp("thr11", 3'd3, 16'd11, 32'h703);
`else
    check("thr_cnt", 64'(bus.fifo_cnt), 64'd4);
    pop_exp("thr9",   3'd0, 16'd9,    32'h700);
    pop_exp("thr10",  3'd1, 16'd10,   32'h701);
    pop_exp("thr-20", 3'd2, 16'hFFEC, 32'h702);
    pop_exp("thr11",  3'd3, 16'd11,   32'h703);
`endif
    check("thr_ovf",   64'(bus.overflow), 64'd0);
    check("thr_empty", 64'(bus.fifo_cnt), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
